// File: rtl/shift_add_mul_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_add_mul_ctrl_if : start/done handshake plus external adder bus |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface shift_add_mul_ctrl_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 clr;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  // Requester side; it also hosts the ripple adder that closes the loop.
  modport master (
    output start, clr, a, b, add_sum, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );

  modport slave (
    input  start, clr, a, b, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );
endinterface
`default_nettype wire

// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_add_mul_ctrl : shift-add unsigned multiplier sequencer driving |
// | an external WIDTH-bit adder, one partial product per cycle. Rev 1.0  |
// +----------------------------------------------------------------------+
module shift_add_mul_ctrl #(
  parameter int WIDTH = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  shift_add_mul_ctrl_if.slave  bus
);

  localparam int              CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_p_hi;
  logic [WIDTH-1:0]     r_p_lo;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_calc;
  logic [2*WIDTH-1:0]   w_next_p;

  assign w_calc = (r_state == S_CALC);

  // Adder operands are forced to zero outside CALC so the adder stays quiet.
  assign bus.add_a   = w_calc ? r_p_hi : '0;
  assign bus.add_b   = (w_calc && r_p_lo[0]) ? r_mcand : '0;
  assign bus.add_cin = 1'b0;

  // Carry becomes the new MSB, so the full 2*WIDTH product never loses it.
  assign w_next_p = {bus.add_cout, bus.add_sum, r_p_lo[WIDTH-1:1]};

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clr) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_mcand <= bus.a;
              r_p_lo  <= bus.b;
              r_p_hi  <= '0;
              r_cnt   <= '0;
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
          end
          S_CALC: begin
            {r_p_hi, r_p_lo} <= w_next_p;
            r_cnt            <= r_cnt + CW'(1);
            if (r_cnt == C_LAST_ITER) begin
              r_product <= w_next_p;
              r_state   <= S_DONE;
              r_done    <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_add_mul_ctrl : bench for the shift-add multiplier sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_shift_add_mul_ctrl;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_add_mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

  // Behavioural stand-in for full_adder_16b.
  assign {bus.add_cout, bus.add_sum} = 17'(bus.add_a) + 17'(bus.add_b) + 17'(bus.add_cin);

  shift_add_mul_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          inject;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; inject >= 0 pulses a stray start (7*7) in that CALC cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int inject, input string name);
    logic [31:0] prev;
    int          n;
    bit          stable;
    prev      = bus.product;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({name, "_busy_on_accept"}, 64'(bus.busy), 64'd1);
    bus.a  = 16'($urandom);
    bus.b  = 16'($urandom);
    n      = 0;
    stable = 1'b1;
    while (!bus.done && n < LAT + 8) begin
      if (bus.product !== prev) stable = 1'b0;
      if (n == inject) begin
        bus.start = 1'b1;
        bus.a     = 16'd7;
        bus.b     = 16'd7;
      end
      tick();
      bus.start = 1'b0;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    chk({name, "_product"}, 64'(bus.product), 64'(exp));
    chk({name, "_product_stable"}, 64'(stable), 64'd1);
    tick();
    chk({name, "_idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    chk({name, "_idle_adder"}, {31'd0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int          inj;
    bit          saw_done;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, -1};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, -1};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000, -1};
    vecs[4] = '{16'h0003, 16'h0005, 32'h0000000F,  5};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, -1};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, -1};
    vecs[7] = '{16'h0001, 16'h8000, 32'h00008000,  0};

    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.a     = 16'h5555;
    bus.b     = 16'hAAAA;
    repeat (3) tick();
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("reset_product", 64'(bus.product), 64'd0);
    chk("reset_adder", {31'd0, bus.add_a, bus.add_b, bus.add_cin}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Back-to-back: each start lands in the cycle right after the previous done.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].inject, $sformatf("vec%0d", i));
    end

    run_op(16'd3, 16'd5, 32'h0000000F, -1, "pre_reset");
    bus.a     = 16'd9;
    bus.b     = 16'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("async_reset_product", 64'(bus.product), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_op(16'd2, 16'd2, 32'd4, -1, "after_reset");

    // clr mid-calculation
    bus.a     = 16'd6;
    bus.b     = 16'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("clr_product_kept", 64'(bus.product), 64'd4);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    chk("clr_no_done", 64'(saw_done), 64'd0);

    // clr wins over the final iteration
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0003;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (LAT - 1) tick();
    chk("clr_last_still_busy", 64'(bus.busy), 64'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_last_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("clr_last_product_kept", 64'(bus.product), 64'd4);

    // clr together with start in IDLE is not an accept
    bus.start = 1'b1;
    bus.clr   = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    chk("clr_start_not_accepted", 64'(bus.busy), 64'd0);
    tick();
    chk("clr_start_still_idle", 64'(bus.busy), 64'd0);

    // Randomized operations against plain multiplication.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'hFFFF;
        1: rb = 16'hFFFF;
        2: ra = 16'h0000;
        default: ;
      endcase
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LAT - 2)) : -1;
      run_op(ra, rb, 32'(ra) * 32'(rb), inj, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
